// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, size and lane helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } lsu_state_e;

  // Access size in bytes from funct3[1:0]; 2'b11 never reaches here as a legal code.
  function automatic logic [2:0] size_bytes(input logic [1:0] f3_sz);
    case (f3_sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // 8-lane mask spanning two consecutive words; bits [7:4] set means the access splits.
  function automatic logic [7:0] lane_mask(input logic [1:0] f3_sz, input logic [1:0] off);
    logic [7:0] base;
    base = (8'd1 << size_bytes(f3_sz)) - 8'd1;
    return base << off;
  endfunction

  // Reserved size codes, and unsigned variants on stores, are rejected.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Selects the addressed bytes from a two-word read window and sign/zero extends them.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [63:0] window,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [31:0] shifted;
  logic        sext;

  // Shift the window down by the byte offset, then extend from the top selected byte.
  always_comb begin
    shifted = window[{off, 3'b000} +: 32];
    sext    = ~funct3[2];
    case (funct3[1:0])
      2'b00:   rdata = {{24{sext & shifted[7]}}, shifted[7:0]};
      2'b01:   rdata = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a four-lane byte-select data memory, splitting word-crossing accesses.
// Latency: aligned response 2 cycles after accept, split 3 cycles, illegal funct3 1 cycle.
// Backpressure: one request in flight; req_ready only in IDLE, next accept the cycle after rsp_valid.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [3:0]            mem_byte_sel,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int IW = ADDR_WIDTH - 2;

  typedef struct packed {
    logic                  we;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } req_t;

  req_t       req_q;
  lsu_state_e state_q, state_d;
  logic [31:0] hold_q;

  logic [IW-1:0] idx, idx_nxt;
  logic [1:0]    off;
  logic [7:0]    mask;
  logic          split;
  logic [63:0]   wshift;
  logic [63:0]   window;
  logic [31:0]   ext_rdata;
  logic          accept;
  logic          addr_hi_unused;

  // Only the low ADDR_WIDTH address bits reach memory.
  assign addr_hi_unused = ^req_addr[31:ADDR_WIDTH];
  assign accept         = req_valid & req_ready;

  // Address split, lane mask and lane-aligned store data from the captured request.
  always_comb begin
    idx     = req_q.addr[ADDR_WIDTH-1:2];
    idx_nxt = idx + IW'(1);
    off     = req_q.addr[1:0];
    mask    = lane_mask(req_q.funct3[1:0], off);
    split   = |mask[7:4];
    wshift  = {32'b0, req_q.wdata} << {off, 3'b000};
    window  = split ? {mem_rdata, hold_q} : {32'b0, mem_rdata};
  end

  lsu_load_extract u_extract (
    .window (window),
    .off    (off),
    .funct3 (req_q.funct3),
    .rdata  (ext_rdata)
  );

  // Capture the request on acceptance; inputs are ignored in every other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.we     <= req_we;
      req_q.funct3 <= req_funct3;
      req_q.addr   <= req_addr[ADDR_WIDTH-1:0];
      req_q.wdata  <= req_wdata;
    end
  end

  // First word of a split load arrives during ACC1 and is held for the RESP merge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (state_q == ACC1 && !req_q.we) begin
      hold_q <= mem_rdata;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs; reset forces idle outputs so an in-flight access is killed immediately.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_err      = 1'b0;
    rsp_rdata    = '0;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_byte_sel = '0;
    mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = f3_illegal(req_we, req_funct3) ? ERR : ACC0;
        end
      end
      ACC0: begin
        mem_addr     = idx;
        mem_byte_sel = mask[3:0];
        mem_we       = req_q.we;
        mem_re       = ~req_q.we;
        mem_wdata    = wshift[31:0];
        state_d      = split ? ACC1 : RESP;
      end
      ACC1: begin
        mem_addr     = idx_nxt;
        mem_byte_sel = mask[7:4];
        mem_we       = req_q.we;
        mem_re       = ~req_q.we;
        mem_wdata    = wshift[63:32];
        state_d      = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = req_q.we ? 32'b0 : ext_rdata;
        state_d   = IDLE;
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d      = IDLE;
      req_ready    = 1'b1;
      rsp_valid    = 1'b0;
      rsp_err      = 1'b0;
      rsp_rdata    = '0;
      mem_addr     = '0;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      mem_byte_sel = '0;
      mem_wdata    = '0;
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the pipeline MEM stage and the byte-laned data memory (four 8-bit BRAM lanes, word-addressed, per-lane byte select, 1-cycle registered read).
- Turns RISC-V RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into lane-select, aligned write data and word address.
- Splits misaligned accesses that cross a word boundary into two word accesses.
- Extracts and sign- or zero-extends load results, and returns one response per request over a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 8, byte-address width of data memory; word index is ADDR_WIDTH-2 bits, depth 2**(ADDR_WIDTH-2) words.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM stage presents a request
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address; only [ADDR_WIDTH-1:0] used, upper bits ignored
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle pulse, request complete
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  qualified by rsp_valid; illegal funct3
- mem_addr  out  ADDR_WIDTH-2  word index to memory
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_byte_sel  out  4  lane enables; bit i = byte lane i (data bits 8i+7:8i)
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  memory read data; valid the cycle after mem_re

Behaviour:
- Reset (synchronous): state=IDLE. Outputs: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_re=0, mem_byte_sel=0, mem_addr=0, mem_wdata=0. Request registers cleared.
- Reset mid-operation: abort. The next cycle has no mem_we/mem_re and no response. A half-written split store stays partially written; this is accepted behaviour.
- Request capture: on an edge with req_valid & req_ready, register we, funct3, addr[ADDR_WIDTH-1:0] and wdata. Inputs are ignored outside IDLE.
- Size and offset: size = 1/2/4 bytes from funct3[1:0]; off = addr[1:0].
- 8-bit lane mask: M = ((1<<size)-1) << off. Split when M[7:4] != 0.
- States:
  - IDLE: on accept, go to ERR if funct3 is illegal (011, 110, 111, or store with funct3[2]=1); otherwise go to ACC0.
  - ACC0: mem_addr=idx (addr[ADDR_WIDTH-1:2]), mem_byte_sel=M[3:0], mem_we=we, mem_re=!we, mem_wdata=W[31:0]. Go to ACC1 if split, else RESP.
  - ACC1: mem_addr=(idx+1) mod 2**(ADDR_WIDTH-2) (wraps from last word to 0), mem_byte_sel=M[7:4], mem_wdata=W[63:32]. For a load, capture mem_rdata (word 0) into a hold register at the end of this cycle. Go to RESP.
  - RESP: rsp_valid=1. For a load, rsp_rdata = extend((window >> 8*off)[size*8-1:0]), where window = {mem_rdata, hold} if split, else {32'b0, mem_rdata}. Go to IDLE.
  - ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0, no memory access. Go to IDLE.
- Store data: W (64-bit) = zero-extended wdata << 8*off.
- Extension: funct3[2]=0 sign-extends from the top selected byte; funct3[2]=1 zero-extends.
- Masking: memory lanes not selected hold stale DOUT. The LSU must use only the selected bytes; stale lanes never reach rsp_rdata.
- Latency from acceptance edge T:
  - Aligned: memory access in cycle T+1, rsp_valid in cycle T+2.
  - Split: accesses in T+1 and T+2, rsp_valid in T+3.
  - Illegal: rsp_valid in T+1.
- Throughput: next accept no earlier than the cycle after rsp_valid (req_ready=1 back in IDLE).
- Outside ACC0/ACC1, mem_we=mem_re=0 and mem_byte_sel=0. mem_addr and mem_wdata are don't-care but must stay stable (no X).

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding (IDLE, ACC0, ACC1, RESP, ERR)
  - size-decode function
- Sub-module lsu_load_extract: purely combinational window shift plus sign/zero extend, reused by future cache work. The FSM and store alignment stay in load_store_unit.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> ACC0 mem_addr=4, byte_sel=1111, wdata 0xDEADBEEF; LW rsp_rdata=0xDEADBEEF at T+2.
- SB addr 0x13 data 0x000000F0, then LB 0x13 / LBU 0x13 -> byte_sel=1000, mem_wdata[31:24]=0xF0; rsp_rdata 0xFFFFFFF0 / 0x000000F0; other bytes of word 4 unchanged.
- SW addr 0x21 data 0x11223344 -> ACC0 addr 8 byte_sel=1110 wdata 0x22334400; ACC1 addr 9 byte_sel=0001 wdata 0x00000011. LW 0x21 returns 0x11223344 at T+3.
- LH addr 0xFF (ADDR_WIDTH=8) after bytes 0xFF=0x80, 0x00=0x7F -> second access wraps to word 0; rsp_rdata=0x00007F80.
- Request funct3=011 -> no mem_we/mem_re; rsp_valid and rsp_err high at T+1, rsp_rdata=0; req_ready low during T+1.
- rst asserted in ACC1 of a split store -> no mem_we in the next cycle, no rsp_valid, req_ready=1; only word 0 lanes were written.
